gelato_tensor_mma: RTL

//  Parametrised tile matrix-multiply-accumulate unit for the Gelato tensor pipe: D = A*B (+C).

---
 rtl/gelato_tensor_mma_if.sv | 34 +++
 rtl/gelato_tensor_mma.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/gelato_tensor_mma_if.sv
// Operand/result bus of the Gelato tile MMA unit.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both 1.
// valid must not depend on ready. Payload must hold while valid && !ready.
interface gelato_tensor_mma_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TILE_M     = 2,
  parameter int TILE_N     = 4,
  parameter int TILE_K     = 4,
  parameter int TAG_WIDTH  = 8
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic                                 in_signed;
  logic                                 in_acc;
  logic                                 in_sat;
  logic [TAG_WIDTH-1:0]                 in_tag;
  logic [TILE_M*TILE_K*DATA_WIDTH-1:0]  in_a;
  logic [TILE_K*TILE_N*DATA_WIDTH-1:0]  in_b;
  logic [TILE_M*TILE_N*DATA_WIDTH-1:0]  in_c;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [TAG_WIDTH-1:0]                 out_tag;
  logic [TILE_M*TILE_N*DATA_WIDTH-1:0]  out_d;

  modport master (
    output in_valid, in_signed, in_acc, in_sat, in_tag, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_tag, out_d
  );

  modport slave (
    input  in_valid, in_signed, in_acc, in_sat, in_tag, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_tag, out_d
  );
endinterface

// File: rtl/gelato_tensor_mma.sv
// Tile matrix-multiply-accumulate D = A*B (+C), one k-slice per cycle, with
// signed/unsigned operands, optional saturation, flush and tag pass-through.
module gelato_tensor_mma #(
  parameter int DATA_WIDTH = 32,
  parameter int TILE_M     = 2,
  parameter int TILE_N     = 4,
  parameter int TILE_K     = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  gelato_tensor_mma_if.slave       bus,
  output logic                     busy,
  output logic [1:0]               dbg_state_o
);

  localparam int W  = DATA_WIDTH;
  localparam int AW = 2 * W + $clog2(TILE_K + 1) + 1;
  localparam int KW = (TILE_K > 1) ? $clog2(TILE_K) : 1;

  localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] UMAX = {{(AW-W){1'b0}}, {W{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [KW-1:0]                     k_q, k_d;
  logic [TILE_M*TILE_K*W-1:0]        a_q;
  logic [TILE_K*TILE_N*W-1:0]        b_q;
  logic                              signed_q;
  logic                              sat_q;
  logic [TAG_WIDTH-1:0]              tag_q;
  logic signed [AW-1:0]              acc_q [TILE_M][TILE_N];
  logic signed [AW-1:0]              acc_d [TILE_M][TILE_N];
  logic                              accept;
  logic                              last_k;
  logic [TILE_M*TILE_N*W-1:0]        out_d_c;

  function automatic logic signed [AW-1:0] ext(input logic [W-1:0] x, input logic s);
    return s ? {{(AW-W){x[W-1]}}, x} : {{(AW-W){1'b0}}, x};
  endfunction

  // Accumulator is wide enough that the true result is exact; only the final
  // narrowing to W bits wraps or clamps.
  function automatic logic [W-1:0] narrow(input logic signed [AW-1:0] v,
                                          input logic s, input logic sat);
    logic [W-1:0] r;
    r = v[W-1:0];
    if (sat) begin
      if (s) begin
        if (v > SMAX)      r = SMAX[W-1:0];
        else if (v < SMIN) r = SMIN[W-1:0];
      end else begin
        if (v[AW-1])       r = '0;
        else if (v > UMAX) r = UMAX[W-1:0];
      end
    end
    return r;
  endfunction

  assign last_k = (k_q == KW'(TILE_K - 1));

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    busy          = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        state_d = ST_MAC;
        accept  = 1'b1;
      end
      ST_MAC:  if (last_k) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // flush outranks both the input accept and the output handshake
    if (flush) begin
      state_d = ST_IDLE;
      accept  = 1'b0;
    end
  end

  always_comb begin
    k_d = k_q;
    if (flush)                 k_d = '0;
    else if (accept)           k_d = '0;
    else if (state_q == ST_MAC) k_d = last_k ? '0 : k_q + KW'(1);
  end

  always_comb begin
    acc_d = acc_q;
    if (flush) begin
      acc_d = '{default: '0};
    end else if (accept) begin
      for (int i = 0; i < TILE_M; i++)
        for (int j = 0; j < TILE_N; j++)
          acc_d[i][j] = bus.in_acc ? ext(bus.in_c[(i*TILE_N+j)*W +: W], bus.in_signed) : '0;
    end else if (state_q == ST_MAC) begin
      for (int i = 0; i < TILE_M; i++)
        for (int j = 0; j < TILE_N; j++)
          acc_d[i][j] = acc_q[i][j]
                      + ext(a_q[(i*TILE_K + int'(k_q))*W +: W], signed_q)
                      * ext(b_q[(int'(k_q)*TILE_N + j)*W +: W], signed_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      sat_q    <= 1'b0;
      tag_q    <= '0;
      acc_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      if (accept) begin
        a_q      <= bus.in_a;
        b_q      <= bus.in_b;
        signed_q <= bus.in_signed;
        sat_q    <= bus.in_sat;
        tag_q    <= bus.in_tag;
      end
    end
  end

  always_comb begin
    out_d_c = '0;
    for (int i = 0; i < TILE_M; i++)
      for (int j = 0; j < TILE_N; j++)
        out_d_c[(i*TILE_N+j)*W +: W] = narrow(acc_q[i][j], signed_q, sat_q);
  end

  assign bus.out_d   = out_d_c;
  assign bus.out_tag = tag_q;
  assign dbg_state_o = state_q;

endmodule
